// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a fixed gate
// window of fin cycles, then reports the count and the divider select it decodes to.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned EXP_BASE    = 2,
  parameter int unsigned TOL         = 1
) (
  input  logic               fin,
  input  logic               reset,
  input  logic               start,
  input  logic               sig_in,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] freq,
  output logic [3:0]         sel_det,
  output logic               overflow
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_e;

  // Smallest k whose expected count EXP_BASE<<k is within TOL; one extra bit
  // keeps the absolute difference from wrapping.
  function automatic logic [3:0] decode(input logic [COUNT_W-1:0] cnt, input logic ovf);
    logic [COUNT_W:0] c, e, d;
    logic [3:0]       s;
    s = 4'd15;
    c = {1'b0, cnt};
    for (int k = 3; k >= 0; k--) begin
      e = (COUNT_W+1)'(EXP_BASE) << k;
      d = (c >= e) ? (c - e) : (e - c);
      if (d <= (COUNT_W+1)'(TOL)) s = 4'(k);
    end
    if (ovf || (cnt == '0)) s = 4'd15;
    return s;
  endfunction

  logic               s1_q, s2_q, s3_q;
  logic               rise;
  state_e             state_q, state_d;
  logic [GW-1:0]      gate_q, gate_d;
  logic [COUNT_W-1:0] edges_q, edges_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] freq_q, freq_d;
  logic [3:0]         sel_q, sel_d;
  logic               ovfo_q, ovfo_d;

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge fin or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edges_d = edges_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    freq_d  = freq_q;
    sel_d   = sel_q;
    ovfo_d  = ovfo_q;
    case (state_q)
      IDLE: begin
        // done_q marks the cycle right after LATCH; a start there is dropped
        if (start && !done_q) begin
          state_d = GATE;
          gate_d  = '0;
          edges_d = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      GATE: begin
        if (rise) begin
          if (&edges_q) ovf_d = 1'b1;
          else          edges_d = edges_q + 1'b1;
        end
        if (gate_q == GATE_LAST) state_d = LATCH;
        else                     gate_d  = gate_q + 1'b1;
      end
      LATCH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        freq_d  = edges_q;
        ovfo_d  = ovf_q;
        sel_d   = decode(edges_q, ovf_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fin or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gate_q  <= '0;
      edges_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      freq_q  <= '0;
      sel_q   <= 4'd15;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edges_q <= edges_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      freq_q  <= freq_d;
      sel_q   <= sel_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign freq     = freq_q;
  assign sel_det  = sel_q;
  assign overflow = ovfo_q;

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a divided-clock signal such as the LED blink output from the clock divider.
- Counts rising edges of an asynchronous input over a fixed gate window of fin cycles.
- Reports the raw edge count.
- Decodes the count back into the 4-bit sel setting that would have produced it.
- Used on the board to self-check divider settings and for bench loop-back.

Parameters:
- GATE_CYCLES, 50000000: gate window length in fin cycles (1 s at 50 MHz).
- COUNT_W, 32: width of edge counter and freq output.
- EXP_BASE, 2: expected edge count per gate for sel=0; sel=k expects EXP_BASE<<k, k=0..3.
- TOL, 1: allowed ± deviation from expected count when decoding sel.

Ports:
- fin, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle request to begin a measurement.
- sig_in, input, 1: signal under test, asynchronous to fin.
- busy, output, 1: high while a measurement is in progress.
- done, output, 1: one-cycle pulse when results update.
- freq, output, COUNT_W: rising edges counted in the last gate window.
- sel_det, output, 4: decoded divider select, 0..3, or 4'd15 for no match.
- overflow, output, 1: edge counter saturated during the last window.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, freq=0, sel_det=4'd15, overflow=0; synchronizer, gate counter and edge counter all cleared.
- Input conditioning:
  - sig_in passes through a 2-FF synchronizer, then one more register for edge detect.
  - rise = s2 & ~s3.
  - A sig_in rising edge appears on rise 3 fin cycles later. Inputs faster than fin/2 are not guaranteed to be counted.
- FSM, states IDLE, GATE, LATCH:
  - IDLE: start=1 -> GATE. Gate counter loads 0 and edge counter loads 0; busy goes 1 on the next cycle.
  - GATE: lasts exactly GATE_CYCLES cycles, gate counter 0..GATE_CYCLES-1.
    - Each cycle with rise=1 increments the edge counter.
    - The edge counter saturates at 2^COUNT_W-1 and sets an internal ovf flag.
    - When the gate counter reaches GATE_CYCLES-1, that cycle's rise is still counted, then the FSM goes to LATCH.
  - LATCH: one cycle.
    - freq <= edge count; overflow <= ovf; sel_det <= decode(edge count).
    - done=1 for this cycle only; busy=0 from the following cycle; -> IDLE.
- start while busy or in LATCH: ignored; no restart, no queueing.
- start asserted in the same cycle that done pulses: ignored. A new start must arrive in IDLE.
- Outputs freq, sel_det and overflow hold their values until the next LATCH; they are not cleared at start.
- Decode:
  - sel_det = k for the smallest k in 0..3 with |count − (EXP_BASE<<k)| ≤ TOL.
  - Otherwise 4'd15. This includes count=0 (stuck input) and overflow=1, which forces 15.
  - Comparison is done at COUNT_W+1 bits unsigned, so no wrap on the subtraction.
- Reset mid-GATE: measurement aborted, all outputs return to reset values, no done pulse.
- Gate timing is independent of sig_in phase; a ±1 count quantization is expected and absorbed by TOL.

Test Plan (bench overrides GATE_CYCLES=1000 unless noted):
1. Reset: hold reset=0 for 5 cycles with sig_in toggling -> busy=0, done=0, freq=0, sel_det=15, overflow=0; release, no start -> outputs unchanged for 2000 cycles.
2. Decode sel 0/2:
   - sig_in period 500 cycles, start -> done exactly 1001–1002 cycles after start; freq=2±1, sel_det=0.
   - Repeat with period 125 -> freq=8±1, sel_det=2.
3. No match:
   - Period 100 -> freq=10±1, sel_det=15.
   - sig_in held 0 -> freq=0, sel_det=15, overflow=0.
4. Saturation: COUNT_W=4, sig_in period 4 -> freq=15, overflow=1, sel_det=15.
5. Handshake:
   - start pulsed again at cycle 300 of the gate -> ignored; single done, freq unchanged vs. an undisturbed run.
   - start coincident with done -> no new measurement.
6. Mid-operation reset: reset=0 at gate cycle 500 -> outputs at reset values, no done.
   - A subsequent start with period 250 -> freq=4±1, sel_det=1.
